// File: rtl/io_event_arbiter_pkg.sv
// Shared definitions for the IO event arbiter.
// Event word layout, default sizes and well-known source slots.
package io_event_arbiter_pkg;

  localparam int NSRC_DEF  = 4;
  localparam int DEPTH_DEF = 8;
  localparam int DW_DEF    = 32;

  localparam int DEV_ID_MSB  = 31;
  localparam int DEV_ID_LSB  = 24;
  localparam int PAYLOAD_MSB = 7;
  localparam int PAYLOAD_LSB = 0;

  localparam int SRC_KEY   = 0;
  localparam int SRC_TIMER = 1;

  function automatic logic [7:0] ev_dev_id(
    input logic [31:0] w
  );
    return w[DEV_ID_MSB:DEV_ID_LSB];
  endfunction

  function automatic logic [7:0] ev_payload(
    input logic [31:0] w
  );
    return w[PAYLOAD_MSB:PAYLOAD_LSB];
  endfunction

endpackage

// File: rtl/io_rr_arb.sv
// Round-robin arbiter for the IO event sources.
// The search starts one past the last granted source.
module io_rr_arb
  import io_event_arbiter_pkg::*;
#(
  parameter int NSRC = NSRC_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC-1:0]           req,
  input  logic                      advance,
  output logic [NSRC-1:0]           gnt,
  output logic [$clog2(NSRC)-1:0]   gnt_idx
);

  localparam int IW = $clog2(NSRC);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  // first requester at or after ptr, wrapping mod NSRC
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NSRC; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NSRC))
        sum = sum - (IW+1)'(NSRC);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // search start moves past the winner only on an accepted grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (advance && found)
      ptr <= (gnt_idx == IW'(NSRC-1)) ? '0
           : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/io_event_arbiter.sv
// IO event arbiter: per-source latches, RR pick, event FIFO to CPU.
// Optional source mask register under IO_EVENT_MASK_EN.
module io_event_arbiter
  import io_event_arbiter_pkg::*;
#(
  parameter int NSRC  = NSRC_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NSRC-1:0]            src_irq,
  input  logic [NSRC*DW-1:0]         src_data,
  input  logic                       cpu_rd,
  output logic [DW-1:0]              cpu_data,
  output logic                       cpu_irq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  input  logic                       ovf_clr,
  input  logic                       mask_we,
  input  logic [NSRC-1:0]            mask_wd
);

  localparam int IW = $clog2(NSRC);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic [DW-1:0]   hold [NSRC];
  logic [DW-1:0]   mem  [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] gnt;
  logic [NSRC-1:0] gnt_push;
  logic [NSRC-1:0] take;
  logic [IW-1:0]   gnt_idx;
  logic            push_ok;
  logic            push;
  logic            pop;
  logic            ovf_set;

`ifdef IO_EVENT_MASK_EN
  // source enable register, all sources on out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mask <= '1;
    else if (mask_we)
      mask <= mask_wd;
  end
`else
  logic unused_mask;
  assign unused_mask = ^{mask_we, mask_wd};
  assign mask = '1;
`endif

  assign take     = src_irq & mask;
  assign req      = pending & mask;
  assign push_ok  = (count != CW'(DEPTH)) || cpu_rd;
  assign push     = (|req) && push_ok;
  assign pop      = cpu_rd && (count != '0);
  assign gnt_push = push ? gnt : '0;
  assign ovf_set  = |(take & pending & ~gnt_push);

  io_rr_arb #(
    .NSRC    (NSRC)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (push),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // per-source latch: newest word wins, grant clears pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NSRC; i++)
        hold[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (take[i]) begin
          hold[i]    <= src_data[i*DW +: DW];
          pending[i] <= 1'b1;
        end else if (gnt_push[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // FIFO storage; contents are only visible while count is nonzero
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= hold[gnt_idx];
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end

  // sticky overflow; a new overwrite beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= 1'b0;
    else if (ovf_set)
      ovf <= 1'b1;
    else if (ovf_clr)
      ovf <= 1'b0;
  end

  assign cpu_irq  = (count != '0);
  assign cpu_data = cpu_irq ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_io_event_arbiter.sv
// Self-checking bench for io_event_arbiter (NSRC=4, DEPTH=8, DW=32).
// Directed cases then random traffic against a queue-based model.
module tb_io_event_arbiter;

  localparam int NSRC  = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSRC-1:0]   src_irq;
  logic [NSRC*DW-1:0] src_data;
  logic              cpu_rd;
  logic [DW-1:0]     cpu_data;
  logic              cpu_irq;
  logic [3:0]        count;
  logic              ovf;
  logic              ovf_clr;
  logic              mask_we;
  logic [NSRC-1:0]   mask_wd;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] m_hold [NSRC];
  bit          m_pend [NSRC];
  int          m_rr;
  bit          m_ovf;
  bit [NSRC-1:0] m_mask;
  logic [31:0] m_q [$];

  io_event_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .src_irq  (src_irq),
    .src_data (src_data),
    .cpu_rd   (cpu_rd),
    .cpu_data (cpu_data),
    .cpu_irq  (cpu_irq),
    .count    (count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .mask_we  (mask_we),
    .mask_wd  (mask_wd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_hold[i] = '0;
      m_pend[i] = 0;
    end
    m_rr   = 0;
    m_ovf  = 0;
    m_mask = '1;
    m_q.delete();
  endtask

  // one clock of the behavioural model, from the inputs seen at the edge
  task automatic model_step();
    bit pend_old [NSRC];
    int g;
    int cnt;
    bit set;
    for (int i = 0; i < NSRC; i++) pend_old[i] = m_pend[i];
    cnt = m_q.size();
    g = -1;
    if (cnt < DEPTH || cpu_rd) begin
      for (int k = 0; k < NSRC; k++) begin
        int j;
        j = (m_rr + k) % NSRC;
        if (g < 0 && m_pend[j] && m_mask[j]) g = j;
      end
    end
    if (cpu_rd && cnt > 0) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(m_hold[g]);
      m_pend[g] = 0;
      m_rr = (g + 1) % NSRC;
    end
    set = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_irq[i] && m_mask[i]) begin
        if (pend_old[i] && g != i) set = 1;
        m_hold[i] = src_data[i*DW +: DW];
        m_pend[i] = 1;
      end
    end
    if (set) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
`ifdef IO_EVENT_MASK_EN
    if (mask_we) m_mask = mask_wd;
`endif
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : 32'h0;
    chk({tag, ".count"}, 32'(count), 32'(m_q.size()));
    chk({tag, ".cpu_irq"}, 32'(cpu_irq), 32'(m_q.size() > 0));
    chk({tag, ".cpu_data"}, cpu_data, exp_data);
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
  endtask

  task automatic clear_inputs();
    src_irq = '0;
    cpu_rd  = 1'b0;
    ovf_clr = 1'b0;
    mask_we = 1'b0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    clear_inputs();
  endtask

  task automatic pulse(input int s, input logic [31:0] w);
    src_irq[s] = 1'b1;
    src_data[s*DW +: DW] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.cpu_irq", 32'(cpu_irq), 32'd0);
    chk("reset.cpu_data", cpu_data, 32'd0);
    chk("reset.ovf", 32'(ovf), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  logic [31:0] wy;

  initial begin
    rst      = 1'b1;
    src_data = '0;
    mask_wd  = '0;
    clear_inputs();
    model_reset();
    #12;
    rst = 1'b0;
    check_all("init");

    // single event from the key source
    pulse(0, 32'h0100_0003);
    tick("t1a");
    chk("t1.irq_early", 32'(cpu_irq), 32'd0);
    tick("t1b");
    chk("t1.irq", 32'(cpu_irq), 32'd1);
    chk("t1.data", cpu_data, 32'h0100_0003);
    chk("t1.count", 32'(count), 32'd1);
    cpu_rd = 1'b1;
    tick("t1c");
    chk("t1.count_after", 32'(count), 32'd0);
    chk("t1.irq_after", 32'(cpu_irq), 32'd0);

    // four simultaneous sources come out in index order from reset
    do_reset();
    pulse(0, 32'hAAAA_0000);
    pulse(1, 32'hBBBB_0001);
    pulse(2, 32'hCCCC_0002);
    pulse(3, 32'hDDDD_0003);
    for (int i = 0; i < 5; i++) tick("t2fill");
    chk("t2.count", 32'(count), 32'd4);
    chk("t2.headA", cpu_data, 32'hAAAA_0000);
    cpu_rd = 1'b1; tick("t2rd");
    chk("t2.headB", cpu_data, 32'hBBBB_0001);
    cpu_rd = 1'b1; tick("t2rd");
    chk("t2.headC", cpu_data, 32'hCCCC_0002);
    cpu_rd = 1'b1; tick("t2rd");
    chk("t2.headD", cpu_data, 32'hDDDD_0003);
    cpu_rd = 1'b1; tick("t2rd");

    // fill to DEPTH, then a blocked source waits for a pop
    for (int i = 0; i < DEPTH; i++) begin
      pulse(0, 32'h0300_0000 | i);
      tick("t3fill");
    end
    tick("t3fill");
    chk("t3.full", 32'(count), 32'd8);
    pulse(2, 32'h0202_0022);
    tick("t3blk");
    tick("t3blk");
    tick("t3blk");
    chk("t3.count_blk", 32'(count), 32'd8);
    cpu_rd = 1'b1;
    tick("t3pop");
    chk("t3.count_pop", 32'(count), 32'd8);

    // overwrite while blocked: only the newest word survives
    pulse(1, 32'h0101_0011);
    tick("t4a");
    wy = 32'h0101_0099;
    pulse(1, wy);
    tick("t4b");
    chk("t4.ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      cpu_rd = 1'b1;
      tick("t4drain");
    end
    chk("t4.last", cpu_data, wy);
    chk("t4.count", 32'(count), 32'd1);
    ovf_clr = 1'b1;
    tick("t4clr");
    chk("t4.ovf_clr", 32'(ovf), 32'd0);
    cpu_rd = 1'b1;
    tick("t4pop");

    // pop on empty, then reset with a partly full FIFO
    cpu_rd = 1'b1;
    tick("t5empty");
    chk("t5.count", 32'(count), 32'd0);
    chk("t5.data", cpu_data, 32'd0);
    for (int i = 0; i < 5; i++) begin
      pulse(0, 32'h0500_0000 | i);
      tick("t5fill");
    end
    tick("t5fill");
    chk("t5.count5", 32'(count), 32'd5);
    do_reset();
    tick("t5post");

`ifdef IO_EVENT_MASK_EN
    mask_we = 1'b1;
    mask_wd = 4'b1101;
    tick("t6mask");
    pulse(1, 32'h0101_0066);
    tick("t6p");
    tick("t6p");
    tick("t6p");
    chk("t6.irq_masked", 32'(cpu_irq), 32'd0);
    mask_we = 1'b1;
    mask_wd = 4'b1111;
    tick("t6un");
    tick("t6un");
    tick("t6un");
    chk("t6.irq_unmasked", 32'(cpu_irq), 32'd0);
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int s = 0; s < NSRC; s++) begin
        if ($urandom_range(3) == 0)
          pulse(s, $urandom);
      end
      cpu_rd  = ($urandom_range(2) == 0);
      ovf_clr = ($urandom_range(15) == 0);
      if ($urandom_range(31) == 0) begin
        mask_we = 1'b1;
        mask_wd = 4'($urandom);
      end
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
